// File: rtl/rst_seq_pkg.sv
// Shared types and limits for the board-level reset sequencer.
package rst_seq_pkg;

  // Upper bound on the number of sequenced reset outputs.
  localparam int unsigned RST_SEQ_MAX_DOMAINS = 16;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    HOLD,
    RELEASE,
    RUN
  } rst_seq_state_e;

endpackage

// File: rtl/rst_sequencer_if.sv
// Sequencer-facing signal bundle: lock/request inputs and the staggered reset outputs.
// With RST_SEQ_WDT_EN defined the bundle also carries the watchdog kick and cause flag.
interface rst_sequencer_if #(
  parameter int unsigned NUM_DOMAINS = 4
);
  logic                   locked_i;
  logic                   sw_rst_req_i;
  logic [NUM_DOMAINS-1:0] rst_n_o;
  logic                   seq_done_o;
`ifdef RST_SEQ_WDT_EN
  logic                   wdt_kick_i;
  logic                   wdt_cause_o;

  modport master (
    input  locked_i,
    input  sw_rst_req_i,
    input  wdt_kick_i,
    output rst_n_o,
    output seq_done_o,
    output wdt_cause_o
  );

  modport slave (
    output locked_i,
    output sw_rst_req_i,
    output wdt_kick_i,
    input  rst_n_o,
    input  seq_done_o,
    input  wdt_cause_o
  );
`else
  modport master (
    input  locked_i,
    input  sw_rst_req_i,
    output rst_n_o,
    output seq_done_o
  );

  modport slave (
    output locked_i,
    output sw_rst_req_i,
    input  rst_n_o,
    input  seq_done_o
  );
`endif
endinterface

// File: rtl/rst_sync.sv
// Flop-chain synchroniser. With ASYNC_CLR the whole chain clears as soon as clr_ni falls,
// which makes it usable as an assert-async / release-sync reset bridge.
module rst_sync #(
  parameter int unsigned STAGES    = 2,
  parameter bit          ASYNC_CLR = 1'b1
) (
  input  logic clk_i,
  input  logic clr_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  if (ASYNC_CLR) begin : g_clr
    // Shift chain with asynchronous clear.
    always_ff @(posedge clk_i or negedge clr_ni) begin
      if (!clr_ni) begin
        chain_q <= '0;
      end else begin
        chain_q <= {chain_q[STAGES-2:0], d_i};
      end
    end
  end else begin : g_noclr
    logic unused_clr_n;
    assign unused_clr_n = clr_ni;

    // Plain shift chain, no reset.
    always_ff @(posedge clk_i) begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Board-level reset sequencer: synchronises pin reset and PLL lock, then releases
// NUM_DOMAINS active-low resets one after another, bit 0 first. Re-sequences on loss of
// lock or a software request. Define RST_SEQ_WDT_EN to add a RUN-state watchdog that
// re-sequences when not kicked and flags the cause on wdt_cause_o.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS = 4,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STEP_CYCLES = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WDT_CYCLES  = 1024
) (
  input logic             IO_CLK,
  input logic             IO_RST_N,
  rst_sequencer_if.master bus
);

  localparam int unsigned CntW = $clog2(HOLD_CYCLES + NUM_DOMAINS * STEP_CYCLES);

  logic rst_int_n;
  logic lock_s;

  // The first flop samples the pin; rst_int_n then rises SYNC_STAGES edges after that
  // sampling edge, by which time the lock chain already holds a settled value.
  rst_sync #(
    .STAGES   (SYNC_STAGES + 1),
    .ASYNC_CLR(1'b1)
  ) u_rst_sync (
    .clk_i (IO_CLK),
    .clr_ni(IO_RST_N),
    .d_i   (1'b1),
    .q_o   (rst_int_n)
  );

  rst_sync #(
    .STAGES   (SYNC_STAGES),
    .ASYNC_CLR(1'b0)
  ) u_lock_sync (
    .clk_i (IO_CLK),
    .clr_ni(1'b1),
    .d_i   (bus.locked_i),
    .q_o   (lock_s)
  );

  rst_seq_state_e         state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [NUM_DOMAINS-1:0] rst_n_q, rst_n_d;
  logic                   seq_done_q, seq_done_d;
  logic [NUM_DOMAINS-1:0] hit;
  logic                   lock_lost;
  logic                   sw_restart;
  logic                   wdt_fire;

  // cnt keeps counting from HOLD entry, so domain k is due when it hits HOLD-1 + k*STEP.
  for (genvar k = 0; k < NUM_DOMAINS; k++) begin : g_hit
    assign hit[k] = (cnt_q == CntW'(HOLD_CYCLES - 1 + k * STEP_CYCLES));
  end

  assign lock_lost  = (state_q != WAIT_LOCK) && !lock_s;
  assign sw_restart = bus.sw_rst_req_i && ((state_q == RELEASE) || (state_q == RUN));

`ifdef RST_SEQ_WDT_EN
  localparam int unsigned WdtW = $clog2(WDT_CYCLES + 1);

  logic [WdtW-1:0] wdt_q, wdt_d;
  logic            wdt_cause_q, wdt_cause_d;

  assign wdt_fire = (state_q == RUN) && lock_s && !bus.wdt_kick_i &&
                    (wdt_q == WdtW'(WDT_CYCLES - 1));

  // Watchdog counts only in RUN; any kick or leaving RUN clears it.
  always_comb begin
    wdt_d       = '0;
    wdt_cause_d = wdt_cause_q;
    if ((state_q == RUN) && !bus.wdt_kick_i && !wdt_fire) begin
      wdt_d = wdt_q + WdtW'(1);
    end
    if (wdt_fire) begin
      wdt_cause_d = 1'b1;
    end else if (bus.sw_rst_req_i) begin
      wdt_cause_d = 1'b0;
    end
  end

  // Watchdog state registers.
  always_ff @(posedge IO_CLK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      wdt_q       <= '0;
      wdt_cause_q <= 1'b0;
    end else begin
      wdt_q       <= wdt_d;
      wdt_cause_q <= wdt_cause_d;
    end
  end

  assign bus.wdt_cause_o = wdt_cause_q;
`else
  logic [31:0] unused_wdt_cycles;
  assign unused_wdt_cycles = WDT_CYCLES;
  assign wdt_fire          = 1'b0;
`endif

  // Next-state and registered-output logic; restart events override the normal flow.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rst_n_d    = rst_n_q;
    seq_done_d = seq_done_q;

    unique case (state_q)
      WAIT_LOCK: begin
        rst_n_d    = '0;
        seq_done_d = 1'b0;
        cnt_d      = '0;
        if (lock_s) begin
          state_d = HOLD;
        end
      end
      HOLD, RELEASE: begin
        cnt_d   = cnt_q + CntW'(1);
        rst_n_d = rst_n_q | hit;
        if (hit[NUM_DOMAINS-1]) begin
          state_d    = RUN;
          seq_done_d = 1'b1;
        end else if (hit[0]) begin
          state_d = RELEASE;
        end
      end
      RUN: begin
      end
      default: state_d = WAIT_LOCK;
    endcase

    if (lock_lost) begin
      state_d    = WAIT_LOCK;
      cnt_d      = '0;
      rst_n_d    = '0;
      seq_done_d = 1'b0;
    end else if (wdt_fire || sw_restart) begin
      state_d    = HOLD;
      cnt_d      = '0;
      rst_n_d    = '0;
      seq_done_d = 1'b0;
    end
  end

  // Sequencer state and output registers, cleared asynchronously by the pin reset.
  always_ff @(posedge IO_CLK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q    <= WAIT_LOCK;
      cnt_q      <= '0;
      rst_n_q    <= '0;
      seq_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rst_n_q    <= rst_n_d;
      seq_done_q <= seq_done_d;
    end
  end

  assign bus.rst_n_o    = rst_n_q;
  assign bus.seq_done_o = seq_done_q;

endmodule
